// File: rtl/ao_vector_sequencer_if.sv
// Signal bundle between the AND-OR cell sequencer and its surroundings.
// The master side is the sequencer; the slave side owns start and the cell output w.
`timescale 1ns/1ps
interface ao_vector_sequencer_if #(
   parameter int LAT_W = 4
);
   logic             start;
   logic             w;
   logic             a;
   logic             b;
   logic             c;
   logic             busy;
   logic             done;
   logic             pass;
   logic [3:0]       err_count;
   logic [LAT_W-1:0] max_lat;
   logic [2:0]       cur_idx;

   modport master (
      input  start, w,
      output a, b, c, busy, done, pass, err_count, max_lat, cur_idx
   );

   modport slave (
      output start, w,
      input  a, b, c, busy, done, pass, err_count, max_lat, cur_idx
   );
endinterface

// File: rtl/ao_vector_sequencer.sv
// On-chip stimulus/check controller for the AND-OR cell w = (a & b) | c: walks the
// 8 input vectors in Gray order, measures settling latency and reports pass/fail.
`timescale 1ns/1ps
module ao_vector_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int LAT_W   = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   ao_vector_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);

   // Gray-coded vector for an index, returned as {a, b, c}.
   function automatic logic [2:0] gray_vec(input logic [2:0] idx);
      return idx ^ {1'b0, idx[2:1]};
   endfunction

   // Reference behaviour of the cell for a given {a, b, c}.
   function automatic logic ao_eval(input logic [2:0] abc);
      return (abc[2] & abc[1]) | abc[0];
   endfunction

   state_t           state_r, state_s;
   logic             sync1_r, sync2_r;
   logic             w_s;
   logic [2:0]       abc_r, abc_s;
   logic [2:0]       idx_r, idx_s;
   logic [LAT_W-1:0] lat_r, lat_s;
   logic [LAT_W-1:0] max_lat_r, max_lat_s;
   logic [3:0]       err_r, err_s;
   logic             timeout_r, timeout_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             pass_r, pass_s;
   logic             exp_s;

   assign w_s   = sync2_r;
   assign exp_s = ao_eval(abc_r);

   // Two-flop synchroniser for the asynchronous cell output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= bus.w;
         sync2_r <= sync1_r;
      end
   end

   // Sequencer state and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         abc_r     <= 3'b000;
         idx_r     <= 3'd0;
         lat_r     <= '0;
         max_lat_r <= '0;
         err_r     <= 4'd0;
         timeout_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         abc_r     <= abc_s;
         idx_r     <= idx_s;
         lat_r     <= lat_s;
         max_lat_r <= max_lat_s;
         err_r     <= err_s;
         timeout_r <= timeout_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         pass_r    <= pass_s;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_s   = state_r;
      abc_s     = abc_r;
      idx_s     = idx_r;
      lat_s     = lat_r;
      max_lat_s = max_lat_r;
      err_s     = err_r;
      timeout_s = timeout_r;
      done_s    = 1'b0;
      pass_s    = pass_r;

      case (state_r)
         IDLE: begin
            if (bus.start) begin
               err_s     = 4'd0;
               max_lat_s = '0;
               pass_s    = 1'b0;
               idx_s     = 3'd0;
               state_s   = DRIVE;
            end else begin
               state_s   = IDLE;
            end
         end
         DRIVE: begin
            abc_s   = gray_vec(idx_r);
            lat_s   = '0;
            state_s = WAIT;
         end
         WAIT: begin
            // A match wins over the timeout on the final allowed cycle.
            if (w_s == exp_s) begin
               state_s = CHECK;
            end else if (lat_r == TIMEOUT_L) begin
               timeout_s = 1'b1;
               state_s   = CHECK;
            end else begin
               lat_s = lat_r + {{(LAT_W-1){1'b0}}, 1'b1};
            end
         end
         CHECK: begin
            if (timeout_r) begin
               err_s = err_r + 4'd1;
            end else if (lat_r > max_lat_r) begin
               max_lat_s = lat_r;
            end else begin
               max_lat_s = max_lat_r;
            end
            timeout_s = 1'b0;
            if (idx_r == 3'd7) begin
               done_s  = 1'b1;
               pass_s  = (err_s == 4'd0);
               state_s = DONE;
            end else begin
               idx_s   = idx_r + 3'd1;
               state_s = DRIVE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      busy_s = (state_s != IDLE);
   end

   assign bus.a         = abc_r[2];
   assign bus.b         = abc_r[1];
   assign bus.c         = abc_r[0];
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.err_count = err_r;
   assign bus.max_lat   = max_lat_r;
   assign bus.cur_idx   = idx_r;

endmodule

// File: tb/tb_ao_vector_sequencer.sv
// Bench for ao_vector_sequencer: a cycle-timeline model of each sweep predicts every
// output on every cycle; the cell is modelled with a programmable delay or a stuck output.
`timescale 1ns/1ps
module tb_ao_vector_sequencer;
   localparam int TIMEOUT = 15;
   localparam int LAT_W   = 4;
   localparam int MAXN    = 400;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ao_vector_sequencer_if #(.LAT_W(LAT_W)) bus ();

   ao_vector_sequencer #(.TIMEOUT(TIMEOUT), .LAT_W(LAT_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Cell model: mode 0 = delayed AND-OR, 1 = stuck at 0, 2 = stuck at 1.
   int          cell_mode  = 0;
   int          cell_delay = 0;
   logic [15:0] pipe       = 16'h0000;
   logic        cell_now;
   assign cell_now = (bus.a & bus.b) | bus.c;
   always @(posedge clk) pipe <= {pipe[14:0], cell_now};
   assign bus.w = (cell_mode == 1) ? 1'b0 :
                  (cell_mode == 2) ? 1'b1 :
                  (cell_delay == 0) ? cell_now : pipe[cell_delay-1];

   logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                3'b110, 3'b111, 3'b101, 3'b100};

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Expected value of every output on each cycle after the start edge.
   logic [2:0] e_abc  [MAXN];
   logic       e_busy [MAXN];
   logic       e_done [MAXN];
   logic       e_pass [MAXN];
   logic [3:0] e_err  [MAXN];
   logic [3:0] e_max  [MAXN];
   logic [2:0] e_idx  [MAXN];
   int         m_T    [8];
   int         end_n;
   int         cur;
   logic [2:0] m_abc;
   logic       m_busy, m_done, m_pass;
   int         m_err, m_max, m_idx;

   function automatic logic ao(input logic [2:0] v);
      return (v[2] & v[1]) | v[0];
   endfunction

   function automatic logic observed(input logic [2:0] v);
      if (cell_mode == 1) return 1'b0;
      else if (cell_mode == 2) return 1'b1;
      else return ao(v);
   endfunction

   task automatic emit_until(input int upto);
      for (int n = cur; n < upto; n++) begin
         e_abc[n]  = m_abc;
         e_busy[n] = m_busy;
         e_done[n] = m_done;
         e_pass[n] = m_pass;
         e_err[n]  = 4'(m_err);
         e_max[n]  = 4'(m_max);
         e_idx[n]  = 3'(m_idx);
      end
      cur = upto;
   endtask

   // The value compared at edge t+k reflects the cell inputs of cycle t+k-3-delay
   // (cell delay plus two synchroniser stages plus the comparing edge).
   task automatic build_model(input logic [2:0] prior);
      int t, m, src, lat;
      bit hit, tmo;
      logic [2:0] s;
      m_abc = prior; m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0;
      m_err = 0; m_max = 0; m_idx = 0; cur = 0;
      t = 1;
      for (int i = 0; i < 8; i++) begin
         m_T[i] = t;
         emit_until(t);
         m_abc = gray_tab[i];
         hit = 1'b0; tmo = 1'b0; lat = 0; m = t;
         for (int k = 1; k <= TIMEOUT + 1 && !hit && !tmo; k++) begin
            src = t + k - 3 - ((cell_mode == 0) ? cell_delay : 0);
            s = (src >= t) ? gray_tab[i] : (src < 0) ? prior : e_abc[src];
            if (observed(s) == ao(gray_tab[i])) begin
               hit = 1'b1; lat = k - 1; m = t + k;
            end else if (k - 1 == TIMEOUT) begin
               tmo = 1'b1; m = t + k;
            end
         end
         emit_until(m + 1);
         if (tmo) m_err++;
         else if (lat > m_max) m_max = lat;
         if (i < 7) begin
            m_idx = i + 1;
            t = m + 2;
         end else begin
            m_done = 1'b1;
            m_pass = (m_err == 0);
            emit_until(m + 2);
            m_done = 1'b0;
            m_busy = 1'b0;
            emit_until(m + 6);
            end_n = m + 5;
         end
      end
   endtask

   // Compare process: every cycle of a sweep against the model timeline.
   bit chk_en = 1'b0;
   int chk_n  = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("abc",       {bus.a, bus.b, bus.c}, e_abc[chk_n]);
         check("busy",      bus.busy,              e_busy[chk_n]);
         check("done",      bus.done,              e_done[chk_n]);
         check("pass",      bus.pass,              e_pass[chk_n]);
         check("err_count", bus.err_count,         e_err[chk_n]);
         check("max_lat",   bus.max_lat,           e_max[chk_n]);
         check("cur_idx",   bus.cur_idx,           e_idx[chk_n]);
         if (chk_n >= end_n) chk_en = 1'b0;
         chk_n++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_sweep(input logic [2:0] prior, input int pulse_at, input bit abort4);
      build_model(prior);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk_n  = 0;
      chk_en = 1'b1;
      for (int i = 0; i < MAXN && chk_en; i++) begin
         @(negedge clk);
         bus.start = (pulse_at > 0 && chk_n == pulse_at);
         if (abort4 && chk_n >= m_T[4] + 2) chk_en = 1'b0;
      end
      bus.start = 1'b0;
      if (chk_en) begin
         check("sweep_timeout", 32'd0, 32'd1);
         chk_en = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_abc"},  {bus.a, bus.b, bus.c}, 32'd0);
      check({tag, "_busy"}, bus.busy,              32'd0);
      check({tag, "_done"}, bus.done,              32'd0);
      check({tag, "_pass"}, bus.pass,              32'd0);
      check({tag, "_err"},  bus.err_count,         32'd0);
      check({tag, "_max"},  bus.max_lat,           32'd0);
      check({tag, "_idx"},  bus.cur_idx,           32'd0);
   endtask

   task automatic check_result(input string tag, input int err, input int mx, input bit ps);
      check({tag, "_model_err"}, m_err,         err);
      check({tag, "_model_max"}, m_max,         mx);
      check({tag, "_err"},       bus.err_count, err);
      check({tag, "_max"},       bus.max_lat,   mx);
      check({tag, "_pass"},      bus.pass,      ps);
      check({tag, "_busy"},      bus.busy,      32'd0);
      check({tag, "_abc_hold"},  {bus.a, bus.b, bus.c}, 32'd4);
   endtask

   initial begin
      int d;
      bus.start = 1'b0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(20);

      cell_mode = 0; cell_delay = 0;
      run_sweep(3'b000, 0, 1'b0);
      check_result("zero_delay", 0, 2, 1'b1);

      cell_delay = 5; idle(20);
      run_sweep(3'b100, 0, 1'b0);
      check_result("delay5", 0, 7, 1'b1);

      // Only idx 1, 3, 4 and 7 move w; idx 6 (111 -> 101) keeps it at 1.
      cell_delay = 14; idle(20);
      run_sweep(3'b100, 0, 1'b0);
      check_result("delay14", 4, 0, 1'b0);

      cell_mode = 1; idle(20);
      run_sweep(3'b100, 0, 1'b0);
      check_result("stuck0", 5, 0, 1'b0);

      cell_mode = 2; idle(20);
      run_sweep(3'b100, 0, 1'b0);
      check_result("stuck1", 3, 0, 1'b0);

      cell_mode = 0; cell_delay = 5; idle(20);
      run_sweep(3'b100, 0, 1'b1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      cell_delay = 0; idle(20);
      run_sweep(3'b000, 20, 1'b0);
      check_result("after_reset", 0, 2, 1'b1);

      for (int r = 0; r < 5; r++) begin
         d = $urandom_range(0, 14);
         cell_delay = d;
         idle(20 + $urandom_range(0, 10));
         run_sweep(3'b100, $urandom_range(1, 40), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "bench time limit");
   end
endmodule
